seg_led_output: RTL and testbench
=================================

# seg_led_output

Memory-mapped output block: the store-side counterpart of the switch input port. When the CPU stores to an output address with IOWriteCtrl asserted, it latches data into LED and seven-segment registers. It then drives 16 LEDs directly and time-multiplexes an 8-digit common-anode seven-segment display, with per-digit enable mask, decimal points, blanking and blink.

## Interface
- SCAN_DIV, 100000: clk cycles each digit stays lit before advancing (≥2).
- BLINK_DIV, 25000000: clk cycles per blink half-period (≥2).
- clk  in  1  system clock; all state updates on falling edge.
- rst  in  1  asynchronous, active-high reset.
- IOWriteCtrl  in  1  store to I/O space this cycle.
- address  in  32  store address.
- write_data  in  32  store data.
- led_out  out  16  LED drive, active-high.
- seg_en  out  8  digit select, active-low, bit i = digit i (digit 0 rightmost).
- seg_out  out  8  segments active-low, {dp,g,f,e,d,c,b,a}.

## Operation
- Register map, written only when IOWriteCtrl=1 and address matches exactly:
  - 0xffff_ffc1: led_reg <= write_data[15:0].
  - 0xffff_ffc3: led_reg[7:0] <= write_data[7:0]; led_reg[15:8] unchanged.
  - 0xffff_ffc5: seg_value <= write_data[31:0]; digit i shows nibble seg_value[4i+3:4i].
  - 0xffff_ffc7: digit_mask <= write_data[7:0]; dp_mask <= write_data[15:8]; blank <= write_data[16]; blink <= write_data[17].
- Any other address, or IOWriteCtrl=0: no register changes. No read-back.
- led_out = led_reg (combinational from register).
- Scan counter scan_cnt counts 0..SCAN_DIV-1. On wrap, digit index idx (3 bits) increments and wraps 7→0.
- Blink counter counts 0..BLINK_DIV-1. On wrap, blink_phase toggles. It runs regardless of the blink bit.
- Digit lit when digit_mask[idx]=1, blank=0, and NOT(blink=1 and blink_phase=1).
- Registered outputs, updated every falling edge from the current idx and registers:
  - lit: seg_en <= ~(8'b1 << idx); seg_out <= {~dp_mask[idx], decode(nibble idx)}.
  - not lit: seg_en <= 8'hFF; seg_out <= 8'hFF.
- decode (7-bit g..a, active-low), shown here as the full byte with dp off:
  - 0–7: C0 F9 A4 B0 99 92 82 F8.
  - 8–F: 80 90 88 83 C6 A1 86 8E.
- Masked digits keep their time slot. Scan period is always 8×SCAN_DIV cycles, so brightness does not change with mask.

## Timing
- Reset (async, immediate) values:
  - led_reg=0, seg_value=0, digit_mask=8'hFF, dp_mask=0, blank=0, blink=0.
  - scan_cnt=0, idx=0, blink counter=0, blink_phase=0.
  - Outputs: led_out=16'h0000, seg_en=8'hFF, seg_out=8'hFF.
- After rst deasserts, the first falling edge gives seg_en=8'hFE, seg_out=8'hC0.
- Register write takes effect at the falling edge where the store is presented.
  - led_out changes at that edge.
  - seg_out/seg_en reflect the new value one falling edge later (output register).
- Write during a digit's slot: the new value appears mid-slot. The scan counter is not restarted.
- A write to 0xffff_ffc7 does not reset the scan or blink counters. Setting blink mid-phase=1 blanks on the next output update.
- scan_cnt wrap and idx increment happen on the same edge. The output for the new idx appears one edge later.
- Simultaneous blink wrap and scan wrap: both take effect; no priority issue.
- rst asserted mid-scan: all state clears immediately; scanning restarts from digit 0.

## Test plan
- Reset, then release, with SCAN_DIV=4, BLINK_DIV=16:
  - During rst: led_out=0, seg_en=FF, seg_out=FF.
  - First edge after release: seg_en=FE, seg_out=C0.
  - seg_en then steps FE→FD→…→7F every 4 cycles and wraps to FE.
- Store 0x0000_A5A5 to ffff_ffc1, then 0x0000_0012 to ffff_ffc3 → led_out=A5A5, then A512. Store to ffff_ffc9 → led_out unchanged.
- Store 0x89AB_CDEF to ffff_ffc5 → digit 0..7 seg_out = 8E,86,A1,C6,83,88,90,80 in scan order.
- Store 0x0000_0F0F to ffff_ffc7 (digit_mask=0F, dp_mask=0F) with seg_value=0:
  - digits 0–3 show seg_out=40 with seg_en active.
  - digits 4–7 give seg_en=FF, seg_out=FF for 4 cycles each.
- Store 0x0002_00FF to ffff_ffc7:
  - digits scan normally for 16 cycles while blink_phase=0.
  - seg_en=FF for the next 16 cycles, then resume.
  - Storing 0x0001_00FF → seg_en=FF continuously.
- Assert rst while idx=5 and led_reg=FFFF → outputs and all registers return to reset values immediately. After release, scan restarts at seg_en=FE.

Source files
------------

// File: rtl/seg_led_output.sv
// Store-side memory-mapped output port: LED register plus an 8-digit
// time-multiplexed common-anode seven-segment display with mask, dp, blank and blink.
module seg_led_output #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IOWriteCtrl,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [15:0] led_out,
  output logic [7:0]  seg_en,
  output logic [7:0]  seg_out
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [31:0] ADDR_LED    = 32'hFFFF_FFC1;
  localparam logic [31:0] ADDR_LED_LO = 32'hFFFF_FFC3;
  localparam logic [31:0] ADDR_SEG    = 32'hFFFF_FFC5;
  localparam logic [31:0] ADDR_CTRL   = 32'hFFFF_FFC7;

  logic [15:0]        led_reg;
  logic [31:0]        seg_value;
  logic [7:0]         digit_mask;
  logic [7:0]         dp_mask;
  logic               blank;
  logic               blink;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [2:0]         idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  logic               scan_wrap;
  logic               blink_wrap;
  logic [3:0]         nibble;
  logic               digit_lit;
  logic [7:0]         next_en;
  logic [7:0]         next_seg;

  // Hex digit to active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode(input logic [3:0] hex);
    logic [6:0] segs;
    case (hex)
      4'h0:    segs = 7'h40;
      4'h1:    segs = 7'h79;
      4'h2:    segs = 7'h24;
      4'h3:    segs = 7'h30;
      4'h4:    segs = 7'h19;
      4'h5:    segs = 7'h12;
      4'h6:    segs = 7'h02;
      4'h7:    segs = 7'h78;
      4'h8:    segs = 7'h00;
      4'h9:    segs = 7'h10;
      4'hA:    segs = 7'h08;
      4'hB:    segs = 7'h03;
      4'hC:    segs = 7'h46;
      4'hD:    segs = 7'h21;
      4'hE:    segs = 7'h06;
      4'hF:    segs = 7'h0E;
      default: segs = 7'h7F;
    endcase
    return segs;
  endfunction

  assign led_out    = led_reg;
  assign scan_wrap  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign blink_wrap = (blink_cnt == BLINK_W'(BLINK_DIV - 1));

  // Select the current digit's nibble and form the next output pattern.
  always_comb begin
    nibble    = seg_value[{idx, 2'b00} +: 4];
    digit_lit = digit_mask[idx] & ~blank & ~(blink & blink_phase);
    next_en   = 8'hFF;
    next_seg  = 8'hFF;
    if (digit_lit) begin
      next_en  = ~(8'b1 << idx);
      next_seg = {~dp_mask[idx], decode(nibble)};
    end else begin
      next_en  = 8'hFF;
      next_seg = 8'hFF;
    end
  end

  // Memory-mapped register writes; only exact address matches take effect.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      led_reg    <= 16'h0000;
      seg_value  <= 32'h0000_0000;
      digit_mask <= 8'hFF;
      dp_mask    <= 8'h00;
      blank      <= 1'b0;
      blink      <= 1'b0;
    end else if (IOWriteCtrl) begin
      case (address)
        ADDR_LED:    led_reg <= write_data[15:0];
        ADDR_LED_LO: led_reg[7:0] <= write_data[7:0];
        ADDR_SEG:    seg_value <= write_data;
        ADDR_CTRL: begin
          digit_mask <= write_data[7:0];
          dp_mask    <= write_data[15:8];
          blank      <= write_data[16];
          blink      <= write_data[17];
        end
        default: ;
      endcase
    end
  end

  // Digit scan: each digit holds its slot for SCAN_DIV cycles, masked or not.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= 3'd0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      idx      <= idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // Free-running blink timebase, independent of the blink enable.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_wrap) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  // Output register for the display drive.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      seg_en  <= 8'hFF;
      seg_out <= 8'hFF;
    end else begin
      seg_en  <= next_en;
      seg_out <= next_seg;
    end
  end

endmodule

// File: tb/tb_seg_led_output.sv
// Randomised self-checking bench for seg_led_output; the reference derives digit
// index and blink phase arithmetically from the number of edges since reset.
module tb_seg_led_output;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 16;

  logic        clk;
  logic        rst;
  logic        IOWriteCtrl;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [15:0] led_out;
  logic [7:0]  seg_en;
  logic [7:0]  seg_out;

  seg_led_output #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst(rst), .IOWriteCtrl(IOWriteCtrl), .address(address),
    .write_data(write_data), .led_out(led_out), .seg_en(seg_en), .seg_out(seg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [7:0]  seg_tbl [16];
  logic [15:0] m_led;
  logic [31:0] m_val;
  logic [7:0]  m_dmask;
  logic [7:0]  m_dpmask;
  logic        m_blank;
  logic        m_blink;
  int          k;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, k);
    end
  endtask

  task automatic model_reset();
    m_led = 16'h0; m_val = 32'h0; m_dmask = 8'hFF; m_dpmask = 8'h00;
    m_blank = 1'b0; m_blink = 1'b0; k = 0;
  endtask

  // One falling edge: drive a store, predict outputs, compare shortly after.
  task automatic cycle(input logic we, input logic [31:0] addr, input logic [31:0] data);
    int d;
    int ph;
    logic [3:0] nib;
    logic [7:0] e_en;
    logic [7:0] e_seg;
    IOWriteCtrl = we;
    address     = addr;
    write_data  = data;
    @(negedge clk);
    d   = (k / SCAN_DIV) % 8;
    ph  = (k / BLINK_DIV) % 2;
    nib = 4'((m_val >> (4 * d)) & 32'hF);
    if (m_dmask[d] && !m_blank && !(m_blink && ph == 1)) begin
      e_en  = 8'hFF ^ (8'h01 << d);
      e_seg = {~m_dpmask[d], seg_tbl[nib][6:0]};
    end else begin
      e_en  = 8'hFF;
      e_seg = 8'hFF;
    end
    if (we) begin
      if (addr == 32'hFFFF_FFC1) m_led = data[15:0];
      else if (addr == 32'hFFFF_FFC3) m_led = {m_led[15:8], data[7:0]};
      else if (addr == 32'hFFFF_FFC5) m_val = data;
      else if (addr == 32'hFFFF_FFC7) begin
        m_dmask = data[7:0]; m_dpmask = data[15:8];
        m_blank = data[16];  m_blink  = data[17];
      end
    end
    k++;
    #1;
    check_eq("led_out", 32'(led_out), 32'(m_led));
    check_eq("seg_en",  32'(seg_en),  32'(e_en));
    check_eq("seg_out", 32'(seg_out), 32'(e_seg));
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    seg_tbl[0]  = 8'hC0; seg_tbl[1]  = 8'hF9; seg_tbl[2]  = 8'hA4; seg_tbl[3]  = 8'hB0;
    seg_tbl[4]  = 8'h99; seg_tbl[5]  = 8'h92; seg_tbl[6]  = 8'h82; seg_tbl[7]  = 8'hF8;
    seg_tbl[8]  = 8'h80; seg_tbl[9]  = 8'h90; seg_tbl[10] = 8'h88; seg_tbl[11] = 8'h83;
    seg_tbl[12] = 8'hC6; seg_tbl[13] = 8'hA1; seg_tbl[14] = 8'h86; seg_tbl[15] = 8'h8E;

    rst = 1'b1; IOWriteCtrl = 1'b0; address = 32'h0; write_data = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_led_out", 32'(led_out), 32'h0);
    check_eq("rst_seg_en",  32'(seg_en),  32'hFF);
    check_eq("rst_seg_out", 32'(seg_out), 32'hFF);
    @(posedge clk);
    rst = 1'b0;

    // Directed sequence following the block's intended use.
    idle(40);
    cycle(1'b1, 32'hFFFF_FFC1, 32'h0000_A5A5);
    cycle(1'b1, 32'hFFFF_FFC3, 32'h0000_0012);
    cycle(1'b1, 32'hFFFF_FFC9, 32'h0000_FFFF);
    cycle(1'b0, 32'hFFFF_FFC1, 32'h0000_1234);
    cycle(1'b1, 32'hFFFF_FFC5, 32'h89AB_CDEF);
    idle(32);
    cycle(1'b1, 32'hFFFF_FFC5, 32'h0000_0000);
    cycle(1'b1, 32'hFFFF_FFC7, 32'h0000_0F0F);
    idle(32);
    cycle(1'b1, 32'hFFFF_FFC7, 32'h0002_00FF);
    idle(64);
    cycle(1'b1, 32'hFFFF_FFC7, 32'h0001_00FF);
    idle(16);
    cycle(1'b1, 32'hFFFF_FFC7, 32'h0000_00FF);
    idle(8);

    // Randomised stores across valid, invalid and disabled accesses.
    for (int i = 0; i < 400; i++) begin
      data = $urandom;
      we   = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0: addr = 32'hFFFF_FFC1;
        1: addr = 32'hFFFF_FFC3;
        2: addr = 32'hFFFF_FFC5;
        3: begin
          addr = 32'hFFFF_FFC7;
          data[16] = ($urandom_range(0, 7) == 0);
          data[17] = ($urandom_range(0, 3) == 0);
        end
        4: addr = 32'hFFFF_FFC9;
        5: addr = 32'hFFFF_FFC0;
        6: addr = $urandom;
        default: begin addr = 32'hFFFF_FFC5; we = 1'b0; end
      endcase
      cycle(we, addr, data);
    end

    // Asynchronous reset in the middle of digit 5 with all LEDs on.
    cycle(1'b1, 32'hFFFF_FFC1, 32'h0000_FFFF);
    for (int i = 0; i < 64 && ((k / SCAN_DIV) % 8) != 5; i++) idle(1);
    check_eq("idx_reached_5", 32'((k / SCAN_DIV) % 8), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_led_out", 32'(led_out), 32'h0);
    check_eq("mid_rst_seg_en",  32'(seg_en),  32'hFF);
    check_eq("mid_rst_seg_out", 32'(seg_out), 32'hFF);
    @(posedge clk);
    rst = 1'b0;
    model_reset();
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
